// File: rtl/stuck_response_analyzer_if.sv
`default_nettype none
// ============================================================================
// Module   : stuck_response_analyzer_if
// Brief    : Response stream and result bus of the stuck-at response analyser.
//            The master drives run control and circuit responses; the slave
//            (analyser) returns handshake, progress and verdict.
// Revision : 1.0 - initial release
// ============================================================================
interface stuck_response_analyzer_if #(
    parameter int VEC_W = 6,
    parameter int SIG_W = 16
);
    logic             start;
    logic             resp_valid;
    logic             resp_ready;
    logic             y_dut;
    logic             y_ref;
    logic [VEC_W-1:0] vec_idx;
    logic             busy;
    logic             done;
    logic             fault_detected;
    logic [VEC_W-1:0] first_fail_idx;
    logic [VEC_W:0]   fail_count;
    logic [SIG_W-1:0] signature;

    modport master (
        output start, resp_valid, y_dut, y_ref,
        input  resp_ready, vec_idx, busy, done, fault_detected,
               first_fail_idx, fail_count, signature
    );

    modport slave (
        input  start, resp_valid, y_dut, y_ref,
        output resp_ready, vec_idx, busy, done, fault_detected,
               first_fail_idx, fail_count, signature
    );
endinterface
`default_nettype wire

// File: rtl/stuck_response_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : stuck_response_analyzer
// Brief    : Output-response analyser for stuck-at fault campaigns. Compares
//            circuit and golden responses per vector, counts mismatches,
//            records the first failing vector and compacts y_dut into a MISR.
// Revision : 1.0 - initial release
// ============================================================================
module stuck_response_analyzer #(
    parameter int               VEC_W   = 6,
    parameter int               NUM_VEC = 64,
    parameter int               SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = 16'h1021,
    parameter logic [SIG_W-1:0] SEED    = 16'hFFFF
) (
    input  logic                        clk,
    input  logic                        rst,
    stuck_response_analyzer_if.slave    bus
);

    localparam logic [VEC_W-1:0] c_LAST_IDX = VEC_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [VEC_W-1:0] r_vec_idx;
    logic             r_fault_detected;
    logic [VEC_W-1:0] r_first_fail_idx;
    logic [VEC_W:0]   r_fail_count;
    logic [SIG_W-1:0] r_signature;

    logic             w_accept;
    logic             w_run_start;
    logic             w_mismatch;
    logic             w_last;
    logic [SIG_W-1:0] w_sig_next;

    // Handshake and per-response decode
    assign w_accept    = bus.resp_valid && (r_state == S_RUN);
    assign w_run_start = bus.start && (r_state != S_RUN);
    assign w_mismatch  = bus.y_dut ^ bus.y_ref;
    assign w_last      = (r_vec_idx == c_LAST_IDX);

    // MISR step: shift left, fold POLY back in when the MSB falls out, inject y_dut
    assign w_sig_next = {r_signature[SIG_W-2:0], 1'b0}
                      ^ (r_signature[SIG_W-1] ? POLY : '0)
                      ^ {{(SIG_W-1){1'b0}}, bus.y_dut};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only honoured outside RUN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_accept && w_last) w_state_next = S_DONE;
            S_DONE:  if (bus.start) w_state_next = S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Result registers: cleared on run entry, updated only on an accept
    always_ff @(posedge clk) begin
        if (rst || w_run_start) begin
            r_vec_idx        <= '0;
            r_fault_detected <= 1'b0;
            r_first_fail_idx <= '0;
            r_fail_count     <= '0;
            r_signature      <= SEED;
        end else if (w_accept) begin
            r_vec_idx   <= w_last ? '0 : r_vec_idx + VEC_W'(1);
            r_signature <= w_sig_next;
            if (w_mismatch) begin
                r_fail_count <= r_fail_count + (VEC_W+1)'(1);
                if (!r_fault_detected) begin
                    r_fault_detected <= 1'b1;
                    r_first_fail_idx <= r_vec_idx;
                end
            end
        end
    end

    assign bus.resp_ready     = (r_state == S_RUN);
    assign bus.busy           = (r_state == S_RUN);
    assign bus.done           = (r_state == S_DONE);
    assign bus.vec_idx        = r_vec_idx;
    assign bus.fault_detected = r_fault_detected;
    assign bus.first_fail_idx = r_first_fail_idx;
    assign bus.fail_count     = r_fail_count;
    assign bus.signature      = r_signature;

endmodule
`default_nettype wire

// File: doc/stuck_response_analyzer.md
Name: stuck_response_analyzer

Overview:
- Output-response analyser for stuck-at fault campaigns; the receiving end of the exhaustive vector stream driven into the fault-injectable circuit.
- For each applied vector it accepts the circuit output (y_dut) and the fault-free copy's output (y_ref).
- Counts mismatches and captures the first failing vector index.
- Compacts y_dut into a MISR signature for signature-based detection.
- Reports a pass/fail verdict after NUM_VEC responses.

Parameters:
- VEC_W, 6, vector index width (number of circuit inputs x1..x6).
- NUM_VEC, 64, responses per run; must be ≤ 2**VEC_W.
- SIG_W, 16, MISR width.
- POLY, 16'h1021, MISR feedback polynomial (taps XORed when MSB shifts out).
- SEED, 16'hFFFF, MISR value loaded at run start.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a run; honoured in IDLE or DONE only.
- resp_valid  input  1  y_dut/y_ref valid for current vector.
- resp_ready  output  1  analyser accepts a response this cycle (high only in RUN).
- y_dut  input  1  output of circuit under test (possibly faulted).
- y_ref  input  1  output of fault-free copy.
- vec_idx  output  VEC_W  index of vector expected next.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- fault_detected  output  1  at least one mismatch seen this run.
- first_fail_idx  output  VEC_W  index of first mismatch; valid only when fault_detected.
- fail_count  output  VEC_W+1  number of mismatching vectors.
- signature  output  SIG_W  MISR state.

Behaviour:
- Reset (rst=1 at edge): state IDLE; vec_idx=0, fault_detected=0, first_fail_idx=0, fail_count=0, signature=SEED, busy=0, done=0, resp_ready=0. Reset has priority over every other input, including mid-run.
- States:
  - IDLE: start → RUN.
  - RUN: accept = resp_valid & resp_ready. An accept with vec_idx==NUM_VEC-1 → DONE.
  - DONE: start → RUN. Otherwise hold all results.
- Entering RUN (from IDLE or DONE): same edge clears vec_idx, fault_detected, first_fail_idx and fail_count, and loads signature=SEED.
- start while in RUN is ignored.
- resp_ready = (state==RUN). Combinational from state only; no dependency on resp_valid.
- Per accept, all updates are registered and visible the cycle after the accepting edge:
  - mismatch = y_dut ^ y_ref.
  - If mismatch: fail_count += 1.
  - If mismatch and fault_detected==0: first_fail_idx = vec_idx and fault_detected = 1. Later mismatches never overwrite first_fail_idx.
  - signature_next = {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ {{SIG_W-1{0}}, y_dut}.
  - vec_idx += 1. On the final accept it wraps to 0 (NUM_VEC=64) or is reset to 0 (NUM_VEC < 2**VEC_W).
- No accept (resp_valid low, or not RUN): all result registers hold. Gaps of any length are legal.
- fail_count never overflows, since its maximum is NUM_VEC ≤ 2**VEC_W.
- Verdict latency: done rises one cycle after the final accept and stays high until start or rst.
- start and rst together: rst wins.
- Inputs in IDLE/DONE are ignored regardless of resp_valid.

Test Plan:
- Fault-free run: start, then 64 back-to-back accepts with y_dut=y_ref (x1..x6 counting order) → done=1 one cycle after the 64th accept; fault_detected=0, fail_count=0, vec_idx=0; signature equals bench MISR model seeded 16'hFFFF.
- Single mismatch: y_dut differs from y_ref only at vector 37 → fault_detected=1, first_fail_idx=37, fail_count=1; signature differs from the fault-free value.
- Multiple mismatches at vectors 5, 6 and 60 → first_fail_idx=5, fail_count=3. first_fail_idx already reads 5 in the cycle after vector 5 is accepted.
- Throttled stream: resp_valid low for 3 cycles between every response, same data as the single-mismatch case → identical final results; resp_ready stays high throughout RUN; no accept during gaps.
- Reset mid-run: rst asserted after 20 accepts with 2 mismatches → next cycle IDLE, all outputs at reset values. A subsequent full fault-free run gives fail_count=0.
- Restart and ignore: start pulsed during RUN at vector 10 → no effect, run completes with correct counts. start in DONE → results cleared the next cycle, busy=1, vec_idx=0, signature=16'hFFFF.
